// File: rtl/regfile_dump_32x64.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_dump_32x64
// Purpose  : Streams a wrapping address range of the 32x64 register file out
//            over valid/ready, fetching two registers per read cycle.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump_32x64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  first,
    input  logic [5:0]  count,
    output logic [4:0]  raA,
    output logic [4:0]  raB,
    input  logic [63:0] rdA,
    input  logic [63:0] rdB,
    output logic [63:0] out_data,
    output logic [4:0]  out_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [5:0]  rem_q, rem_d;
    logic [63:0] buf0_data_q, buf0_data_d;
    logic [4:0]  buf0_addr_q, buf0_addr_d;
    logic [63:0] buf1_data_q, buf1_data_d;
    logic [4:0]  buf1_addr_q, buf1_addr_d;
    logic        head_q, head_d;
    logic [1:0]  fill_q, fill_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= 5'd0;
            rem_q       <= 6'd0;
            buf0_data_q <= 64'd0;
            buf0_addr_q <= 5'd0;
            buf1_data_q <= 64'd0;
            buf1_addr_q <= 5'd0;
            head_q      <= 1'b0;
            fill_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            buf0_data_q <= buf0_data_d;
            buf0_addr_q <= buf0_addr_d;
            buf1_data_q <= buf1_data_d;
            buf1_addr_q <= buf1_addr_d;
            head_q      <= head_d;
            fill_q      <= fill_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        buf0_data_d = buf0_data_q;
        buf0_addr_d = buf0_addr_q;
        buf1_data_d = buf1_data_q;
        buf1_addr_d = buf1_addr_q;
        head_d      = head_q;
        fill_d      = fill_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = first;
                    rem_d   = (count > 6'd32) ? 6'd32 : count;
                    state_d = (count == 6'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                buf0_data_d = rdA;
                buf0_addr_d = ptr_q;
                head_d      = 1'b0;
                if (rem_q >= 6'd2) begin
                    buf1_data_d = rdB;
                    buf1_addr_d = ptr_q + 5'd1;
                    fill_d      = 2'd2;
                    rem_d       = rem_q - 6'd2;
                end else begin
                    fill_d = 2'd1;
                    rem_d  = 6'd0;
                end
                // 5-bit pointer wraps naturally past register 31
                ptr_d   = ptr_q + 5'd2;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (fill_q == 2'd1) begin
                        fill_d  = 2'd0;
                        head_d  = 1'b0;
                        state_d = (rem_q != 6'd0) ? S_FETCH : S_DONE;
                    end else begin
                        fill_d = fill_q - 2'd1;
                        head_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign raA       = ptr_q;
    assign raB       = ptr_q + 5'd1;
    assign out_data  = head_q ? buf1_data_q : buf0_data_q;
    assign out_addr  = head_q ? buf1_addr_q : buf0_addr_q;
    assign out_valid = (state_q == S_DRAIN);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_32x64.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_32x64
// Purpose  : Directed, table-driven bench for regfile_dump_32x64.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_32x64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  first;
    logic [5:0]  count;
    logic [4:0]  raA, raB;
    logic [63:0] rdA, rdB;
    logic [63:0] out_data;
    logic [4:0]  out_addr;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [63:0] rf [32];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    assign rdA = rf[raA];
    assign rdB = rf[raB];

    regfile_dump_32x64 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .first     (first),
        .count     (count),
        .raA       (raA),
        .raB       (raB),
        .rdA       (rdA),
        .rdB       (rdB),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    typedef struct {
        logic [4:0] first;
        logic [5:0] count;
        int         words;
        int         done_cyc;
        int         last_ra;
        bit         repulse;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // exp_done < 0 or exp_ra < 0 skips that comparison
    task automatic run_dump(input logic [4:0] f, input logic [5:0] c, input int exp_words,
                            input int exp_done, input int exp_ra, input bit repulse, input bit bp);
        int          cyc;
        int          nw;
        int          dc;
        int          lra;
        logic [4:0]  exp_addr;
        logic        stall_prev;
        logic [63:0] hold_d;
        logic [4:0]  hold_a;
        @(negedge clk);
        first     = f;
        count     = c;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
        cyc        = 0;
        nw         = 0;
        dc         = -1;
        lra        = -1;
        stall_prev = 1'b0;
        hold_d     = 64'd0;
        hold_a     = 5'd0;
        while (cyc < 300 && dc < 0) begin
            if (bp) out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (stall_prev) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_data", out_data, hold_d);
                chk("stall_addr", {59'd0, out_addr}, {59'd0, hold_a});
            end
            if (busy && !out_valid && !done) lra = int'(raA);
            if (out_valid && out_ready) begin
                exp_addr = f + 5'(nw);
                chk("word_addr", {59'd0, out_addr}, {59'd0, exp_addr});
                chk("word_data", out_data, rf[exp_addr]);
                nw++;
            end
            if (done) begin
                dc = cyc;
                chk("busy_in_done", {63'd0, busy}, 64'd1);
                chk("valid_in_done", {63'd0, out_valid}, 64'd0);
            end
            stall_prev = out_valid && !out_ready;
            hold_d     = out_data;
            hold_a     = out_addr;
            if (repulse && cyc == 3) begin
                first = 5'd20;
                count = 6'd1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (dc < 0) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", {63'd0, (dc >= 0)}, 64'd1);
        chk("word_count", 64'(nw), 64'(exp_words));
        if (exp_done >= 0) chk("done_cycle", 64'(dc), 64'(exp_done));
        if (exp_ra >= 0) chk("last_fetch_raA", 64'(lra), 64'(exp_ra));
        @(posedge clk);
        #1;
        chk("busy_after_done", {63'd0, busy}, 64'd0);
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int nseen;
        int k;
        vecs[0] = '{5'd0,  6'd32, 32, 48, 30, 1'b0};
        vecs[1] = '{5'd30, 6'd5,  5,  8,  2,  1'b0};
        vecs[2] = '{5'd5,  6'd1,  1,  2,  5,  1'b0};
        vecs[3] = '{5'd7,  6'd2,  2,  3,  7,  1'b0};
        vecs[4] = '{5'd10, 6'd0,  0,  0,  -1, 1'b0};
        vecs[5] = '{5'd3,  6'd40, 32, 48, 1,  1'b0};
        vecs[6] = '{5'd31, 6'd3,  3,  5,  1,  1'b0};
        vecs[7] = '{5'd0,  6'd6,  6,  9,  4,  1'b1};

        for (int i = 0; i < 32; i++) rf[i] = 64'h1111_1111_1111_1111 * 64'(i);

        rst       = 1'b0;
        start     = 1'b1;
        first     = 5'd0;
        count     = 6'd2;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_raA", {59'd0, raA}, 64'd0);
        chk("rst_raB", {59'd0, raB}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_addr", {59'd0, out_addr}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_no_start_yet", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        chk("release_start_edge", {63'd0, busy}, 64'd1);
        start = 1'b0;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("first_dump_ends", {63'd0, busy}, 64'd0);

        for (int i = 0; i < 8; i++)
            run_dump(vecs[i].first, vecs[i].count, vecs[i].words, vecs[i].done_cyc,
                     vecs[i].last_ra, vecs[i].repulse, 1'b0);

        run_dump(5'd12, 6'd4, 4, -1, 14, 1'b0, 1'b1);

        // Asynchronous abort between words of an 8-word dump
        @(negedge clk);
        first = 5'd4;
        count = 6'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nseen = 0;
        k     = 0;
        while (nseen < 3 && k < 50) begin
            if (out_valid && out_ready) nseen++;
            @(posedge clk);
            #1;
            k++;
        end
        chk("abort_reached_words", 64'(nseen), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_raA", {59'd0, raA}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", {63'd0, done}, 64'd0);
        end

        run_dump(5'd8, 6'd4, 4, 6, 10, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
